// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program store, PC and fetch FSM with valid/ready issue.
// Optional redirect support is compiled in with `define IFU_JUMP_EN.
module instr_fetch_unit #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD = {INSTR_WIDTH{1'b1}},
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [PC_BITS-1:0]     pc_out,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   issue_count,
    input  logic                   jump_valid,
    input  logic [PC_BITS-1:0]     jump_addr
);

    localparam int DEPTH = 2 ** PC_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic stopped;
    logic mem_we;
    logic xfer;
    logic jump_req;
    logic cnt_sat;

    assign stopped = (state_q == S_IDLE) || (state_q == S_HALT);
    assign mem_we  = stopped && prog_we;
    assign cnt_sat = (cnt_q == {CNT_WIDTH{1'b1}});

    // A fetched sentinel is never presented to the consumer.
    assign instr_valid = (state_q == S_ISSUE) && (instr_q != HALT_WORD);
    assign xfer        = instr_valid && instr_ready;

`ifdef IFU_JUMP_EN
    assign jump_req = jump_valid &&
                      ((state_q == S_FETCH) || (state_q == S_ISSUE));
`else
    logic jump_unused;
    assign jump_unused = jump_valid ^ (^jump_addr);
    assign jump_req    = 1'b0;
`endif

    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign halted      = (state_q == S_HALT);
    assign issue_count = cnt_q;

    // Program store: written only while fetch is stopped, never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Next-state logic for the fetch FSM, PC, fetched word and counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                instr_d = mem[pc_q];
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (xfer) begin
                    pc_d    = pc_q + PC_BITS'(1);
                    cnt_d   = cnt_sat ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    state_d = S_FETCH;
                end else if (instr_q == HALT_WORD) begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A redirect overrides the sequential PC but keeps any
        // handshake that completed in the same cycle.
        if (jump_req) begin
            pc_d    = jump_addr;
            state_d = S_FETCH;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
